spi_led_regfile: RTL and testbench

SPI_LED_REGFILE -- requirements
Module: spi_led_regfile

---
 rtl/spi_led_regfile.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_led_regfile.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_led_regfile.sv
// -----------------------------------------------------------------------------
// spi_led_regfile
//
// SPI (mode 0) slave exposing a small register file that drives a bank of LEDs.
// A frame is an 8-bit command {rw, addr[6:0]} followed by any number of
// WORD_W-bit data words. The address auto-increments after every data word.
//
// Register map:
//   0x00 LED      rw  led[N_LED-1:0]
//   0x01 LED_SET  w1s (reads LED)
//   0x02 LED_CLR  w1c (reads LED)
//   0x03 STATUS   ro  {err_cnt[3:0], frame_cnt[3:0]}
//   0x04 ID       ro  ID_VAL
//
// Ports:
//   reset   in   asynchronous, active-high reset
//   sclk    in   SPI clock (only clock of the block)
//   cs_n    in   chip select, active low; high clears all frame state
//   mosi    in   serial data in, MSB first, sampled on rising sclk
//   miso    out  serial data out, MSB first, updated on falling sclk
//   led     out  LED drive, 1 = on
//   wr_stb  out  one-sclk pulse per committed register write
// -----------------------------------------------------------------------------
module spi_led_regfile #(
    parameter int         N_LED  = 8,
    parameter int         WORD_W = 8,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic [N_LED-1:0] led,
    output logic             wr_stb
);

    localparam int               CNT_W     = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

    typedef enum logic {PH_CMD, PH_DATA} phase_t;

    // Frame state (cleared by reset or cs_n high)
    phase_t             phase_reg, phase_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-2:0]  shift_reg, shift_next;
    logic               rw_reg, rw_next;
    logic [6:0]         addr_reg, addr_next;
    logic [WORD_W-1:0]  tx_reg, tx_next;
    logic               miso_reg;
    logic               blocked_reg;

    // Persistent state (cleared by reset only)
    logic [N_LED-1:0]   led_reg, led_next;
    logic [3:0]         err_cnt_reg, err_cnt_next;
    logic [3:0]         frame_cnt_reg, frame_cnt_next;
    logic               wr_stb_reg, wr_stb_next;

    logic               active;
    logic               cmd_done;
    logic               word_done;
    logic               wr_commit;
    logic [7:0]         cmd_in;
    logic [WORD_W-1:0]  word_in;
    logic [N_LED-1:0]   word_led;
    logic [6:0]         rd_addr;
    logic [WORD_W-1:0]  rd_word;
    logic [CNT_W-1:0]   tx_idx;

    // A reset that lands mid-frame leaves the master part-way through a
    // frame. blocked_reg is set by reset while cs_n is low and only cs_n
    // going high clears it, so the remainder of that frame is ignored.
    always_ff @(posedge reset or posedge cs_n) begin
        if (cs_n) begin
            blocked_reg <= 1'b0;
        end else begin
            blocked_reg <= 1'b1;
        end
    end

    // Incoming bits: the current mosi completes the byte/word on this edge.
    assign active    = ~blocked_reg;
    assign cmd_in    = {shift_reg[6:0], mosi};
    assign word_in   = {shift_reg, mosi};
    assign word_led  = word_in[N_LED-1:0];
    assign cmd_done  = active && (phase_reg == PH_CMD)  && (bit_cnt_reg == CMD_LAST);
    assign word_done = active && (phase_reg == PH_DATA) && (bit_cnt_reg == WORD_LAST);
    assign wr_commit = word_done && !rw_reg;

    // Read word is fetched on the edge that completes the command (start
    // address) or a data word (next address). Registers are read before this
    // edge's updates, so STATUS shows frame_cnt excluding the current frame.
    assign rd_addr = (phase_reg == PH_CMD) ? cmd_in[6:0] : addr_reg + 7'd1;

    always_comb begin
        rd_word = '0;
        case (rd_addr)
            7'h00, 7'h01, 7'h02: rd_word = WORD_W'(led_reg);
            7'h03:               rd_word = WORD_W'({err_cnt_reg, frame_cnt_reg});
            7'h04:               rd_word = WORD_W'(ID_VAL);
            default:             rd_word = '0;
        endcase
    end

    // Frame sequencing: CMD byte, then repeating DATA words until cs_n rises.
    always_comb begin
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        rw_next      = rw_reg;
        addr_next    = addr_reg;
        tx_next      = tx_reg;
        if (active) begin
            shift_next = word_in[WORD_W-2:0];
            case (phase_reg)
                PH_CMD: begin
                    if (bit_cnt_reg == CMD_LAST) begin
                        phase_next   = PH_DATA;
                        bit_cnt_next = '0;
                        rw_next      = cmd_in[7];
                        addr_next    = cmd_in[6:0];
                        tx_next      = cmd_in[7] ? rd_word : '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                PH_DATA: begin
                    if (bit_cnt_reg == WORD_LAST) begin
                        bit_cnt_next = '0;
                        addr_next    = addr_reg + 7'd1;
                        tx_next      = rw_reg ? rd_word : '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                default: phase_next = PH_CMD;
            endcase
        end
    end

    always_ff @(posedge sclk or posedge reset or posedge cs_n) begin
        if (reset || cs_n) begin
            phase_reg   <= PH_CMD;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            rw_reg      <= 1'b0;
            addr_reg    <= '0;
            tx_reg      <= '0;
        end else begin
            phase_reg   <= phase_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            rw_reg      <= rw_next;
            addr_reg    <= addr_next;
            tx_reg      <= tx_next;
        end
    end

    // Register writes, error and frame counters.
    always_comb begin
        led_next       = led_reg;
        err_cnt_next   = err_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        wr_stb_next    = 1'b0;
        if (cmd_done) begin
            frame_cnt_next = frame_cnt_reg + 4'd1;
        end
        if (wr_commit) begin
            case (addr_reg)
                7'h00: begin
                    led_next    = word_led;
                    wr_stb_next = 1'b1;
                end
                7'h01: begin
                    led_next    = led_reg | word_led;
                    wr_stb_next = 1'b1;
                end
                7'h02: begin
                    led_next    = led_reg & ~word_led;
                    wr_stb_next = 1'b1;
                end
                default: begin
                    if (err_cnt_reg != 4'hF) begin
                        err_cnt_next = err_cnt_reg + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            led_reg       <= '0;
            err_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            wr_stb_reg    <= 1'b0;
        end else begin
            led_reg       <= led_next;
            err_cnt_reg   <= err_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            wr_stb_reg    <= wr_stb_next;
        end
    end

    // bit_cnt_reg is the index of the next bit the master will sample, so the
    // falling edge presents tx_reg MSB-first against it.
    assign tx_idx = WORD_LAST - bit_cnt_reg;

    always_ff @(negedge sclk or posedge reset or posedge cs_n) begin
        if (reset || cs_n) begin
            miso_reg <= 1'b0;
        end else if (phase_reg == PH_DATA) begin
            miso_reg <= tx_reg[tx_idx];
        end else begin
            miso_reg <= 1'b0;
        end
    end

    assign miso   = miso_reg;
    assign led    = led_reg;
    assign wr_stb = wr_stb_reg;

endmodule

// File: tb/tb_spi_led_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_led_regfile
//
// Bit-banged SPI master driving spi_led_regfile. Expected values come from a
// small register model and are queued when a frame is issued, then popped and
// compared once the frame has completed.
// -----------------------------------------------------------------------------
module tb_spi_led_regfile;

    localparam int WORD_W = 8;
    localparam int N_LED  = 8;

    logic             reset;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [N_LED-1:0] led;
    logic             wr_stb;

    spi_led_regfile #(
        .N_LED  (N_LED),
        .WORD_W (WORD_W),
        .ID_VAL (8'hA5)
    ) dut (
        .reset  (reset),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .led    (led),
        .wr_stb (wr_stb)
    );

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Register model
    logic [7:0]  led_m;
    logic [3:0]  err_m;
    logic [3:0]  frame_m;

    logic [31:0] tx_words[8];
    logic [31:0] rx_words[8];
    logic [7:0]  cmd_rx;
    int          stb_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_underflow", got, 32'hDEAD_BEEF);
        end else begin
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [6:0] a);
        case (a)
            7'h00, 7'h01, 7'h02: return {24'h0, led_m};
            7'h03:               return {24'h0, err_m, frame_m};
            7'h04:               return 32'h0000_00A5;
            default:             return 32'h0;
        endcase
    endfunction

    // One SPI bit: mosi set with sclk low, miso sampled just before the rising
    // edge, wr_stb sampled just after the falling edge.
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #4;
        r = miso;
        sclk = 1'b1;
        #5;
        sclk = 1'b0;
        #1;
        if (wr_stb === 1'b1) stb_cnt++;
    endtask

    // abort_bits < 0: send all words; otherwise stop after that many data bits.
    task automatic spi_frame(input logic [7:0] cmd, input int n_words, input int abort_bits);
        logic r;
        int   sent;
        stb_cnt = 0;
        cs_n = 1'b0;
        #5;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(cmd[i], r);
            cmd_rx[i] = r;
        end
        sent = 0;
        for (int w = 0; w < n_words; w++) begin
            rx_words[w] = '0;
            for (int b = WORD_W - 1; b >= 0; b--) begin
                if (abort_bits < 0 || sent < abort_bits) begin
                    spi_bit(tx_words[w][b], r);
                    rx_words[w][b] = r;
                    sent++;
                end
            end
        end
        mosi = 1'b0;
        #4;
        cs_n = 1'b1;
        #10;
        $display("frame cmd=0x%02h words=%0d cut=%0d wr_stb_pulses=%0d led=0x%02h miso_idle=%0b",
                 cmd, n_words, abort_bits, stb_cnt, led, miso);
    endtask

    task automatic do_write(input logic [6:0] addr, input int n, input int abort_bits);
        int         nfull;
        int         exp_stb;
        logic [6:0] a;
        logic [7:0] v;
        nfull   = (abort_bits < 0) ? n : abort_bits / WORD_W;
        exp_stb = 0;
        frame_m = frame_m + 4'd1;
        for (int w = 0; w < nfull; w++) begin
            a = addr + 7'(w);
            v = tx_words[w][7:0];
            case (a)
                7'h00: begin led_m = v;          exp_stb++; end
                7'h01: begin led_m = led_m | v;  exp_stb++; end
                7'h02: begin led_m = led_m & ~v; exp_stb++; end
                default: if (err_m != 4'hF) err_m = err_m + 4'd1;
            endcase
        end
        sb_push("wr_led", {24'h0, led_m});
        sb_push("wr_stb_pulses", 32'(exp_stb));
        sb_push("miso_idle", 32'h0);
        spi_frame({1'b0, addr}, n, abort_bits);
        sb_check({24'h0, led});
        sb_check(32'(stb_cnt));
        sb_check({31'h0, miso});
    endtask

    task automatic do_read(input logic [6:0] addr, input int n);
        sb_push("rd_miso_cmd", 32'h0);
        sb_push("rd_word0", model_rd(addr));
        frame_m = frame_m + 4'd1;
        for (int w = 1; w < n; w++) begin
            sb_push($sformatf("rd_word%0d", w), model_rd(addr + 7'(w)));
        end
        sb_push("rd_wr_stb_pulses", 32'h0);
        spi_frame({1'b1, addr}, n, -1);
        sb_check({24'h0, cmd_rx});
        for (int w = 0; w < n; w++) begin
            sb_check(rx_words[w]);
        end
        sb_check(32'(stb_cnt));
    endtask

    initial begin
        logic r;
        reset = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        led_m = '0;
        err_m = '0;
        frame_m = '0;
        #3;
        reset = 1'b1;
        #5;
        check_val("rst_led", {24'h0, led}, 32'h0);
        check_val("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        check_val("rst_miso", {31'h0, miso}, 32'h0);
        reset = 1'b0;
        #10;

        // Plain write
        tx_words[0] = 32'h5A;
        do_write(7'h00, 1, -1);

        // Set/clear burst from 0x01 starting at led=0x50
        tx_words[0] = 32'h50;
        do_write(7'h00, 1, -1);
        tx_words[0] = 32'h0F;
        tx_words[1] = 32'h03;
        do_write(7'h01, 2, -1);

        // STATUS then ID
        do_read(7'h03, 2);

        // Writes to read-only ID: discarded, err_cnt saturates
        for (int k = 0; k < 17; k++) begin
            tx_words[0] = 32'hFF;
            do_write(7'h04, 1, -1);
        end
        do_read(7'h03, 1);

        // Partial word is discarded, next frame behaves normally
        tx_words[0] = 32'h33;
        do_write(7'h00, 1, 5);
        do_write(7'h00, 1, -1);

        // Address wrap 0x7F -> 0x00
        do_read(7'h7F, 2);

        // Write burst across LED, LED_SET, LED_CLR then read them back
        tx_words[0] = 32'hAA;
        tx_words[1] = 32'h0F;
        tx_words[2] = 32'hA0;
        do_write(7'h00, 3, -1);
        do_read(7'h00, 3);

        // Unmapped read returns zero, no error
        do_read(7'h10, 1);

        // Reset mid-frame: rest of that frame is ignored
        stb_cnt = 0;
        cs_n = 1'b0;
        #5;
        for (int i = 0; i < 8; i++) spi_bit(1'b0, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
        reset = 1'b1;
        #5;
        check_val("midrst_led", {24'h0, led}, 32'h0);
        led_m = '0;
        err_m = '0;
        frame_m = '0;
        reset = 1'b0;
        #5;
        stb_cnt = 0;
        sb_push("blocked_led", 32'h0);
        sb_push("blocked_wr_stb_pulses", 32'h0);
        for (int i = 0; i < 13; i++) spi_bit(1'b1, r);
        cs_n = 1'b1;
        #10;
        $display("frame aborted-by-reset tail bits=13 wr_stb_pulses=%0d led=0x%02h", stb_cnt, led);
        sb_check({24'h0, led});
        sb_check(32'(stb_cnt));

        tx_words[0] = 32'h42;
        do_write(7'h00, 1, -1);
        do_read(7'h03, 1);

        if (exp_q.size() != 0) begin
            check_val("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
